// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM with a 1-cycle registered read.
// Round-robin with a bounded burst; at most one RAM access is granted per cycle.
//
// state      | meaning
// owner      | requester that won the most recent grant
// burst_cnt  | consecutive grants to owner, 0 after an idle cycle, saturates at MAX_BURST
// rsp_pend   | read accepted last cycle per requester; RAM data is valid now
module ram_arbiter #(
    parameter int WIDTH     = 64,
    parameter int SIZE      = 512,
    parameter int MAX_BURST = 4,
    localparam int ABITS    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [ABITS-1:0] req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [ABITS-1:0] req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,

    output logic             ram_rden,
    output logic [ABITS-1:0] ram_rdaddr,
    input  logic [WIDTH-1:0] ram_rddata,
    output logic             ram_wren,
    output logic [ABITS-1:0] ram_wraddr,
    output logic [WIDTH-1:0] ram_wrdata
);

    localparam int            BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    logic             owner;
    logic [BW-1:0]    burst_cnt;
    logic [1:0]       rsp_pend;
    logic [WIDTH-1:0] hold0;
    logic [WIDTH-1:0] hold1;

    logic             pick1;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    logic             gnt_we;
    logic [ABITS-1:0] gnt_addr;

    // Under contention the owner keeps the RAM until its burst is spent.
    always_comb begin
        pick1    = (burst_cnt < BMAX) ? owner : ~owner;
        gnt0     = req0_valid & (~req1_valid | ~pick1);
        gnt1     = req1_valid & (~req0_valid | pick1);
        gnt_any  = gnt0 | gnt1;
        gnt_we   = gnt1 ? req1_we   : req0_we;
        gnt_addr = gnt1 ? req1_addr : req0_addr;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign ram_wren   = gnt_any & gnt_we;
    assign ram_rden   = gnt_any & ~gnt_we;
    assign ram_wraddr = gnt_addr;
    assign ram_rdaddr = gnt_addr;
    assign ram_wrdata = gnt1 ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
            rsp_pend  <= '0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            if (gnt_any) begin
                if (gnt1 == owner) begin
                    if (burst_cnt != BMAX) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    owner     <= gnt1;
                    burst_cnt <= BW'(1);
                end
            end else begin
                burst_cnt <= '0;
            end
            rsp_pend <= {gnt1 & ~req1_we, gnt0 & ~req0_we};
            if (rsp_pend[0]) begin
                hold0 <= ram_rddata;
            end
            if (rsp_pend[1]) begin
                hold1 <= ram_rddata;
            end
        end
    end

    // Read data passes straight through; the hold registers keep it stable between responses.
    assign rsp0_valid = rsp_pend[0];
    assign rsp1_valid = rsp_pend[1];
    assign rsp0_data  = rsp_pend[0] ? ram_rddata : hold0;
    assign rsp1_data  = rsp_pend[1] ? ram_rddata : hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model, a reference model of arbitration and responses
// checked every cycle, and directed scenarios with literal expectations.
module tb_ram_arbiter;

    localparam int W  = 64;
    localparam int S  = 512;
    localparam int MB = 4;
    localparam int AB = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AB-1:0] req0_addr = '0;
    logic [W-1:0]  req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AB-1:0] req1_addr = '0;
    logic [W-1:0]  req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp0_data, rsp1_data;
    logic          ram_rden, ram_wren;
    logic [AB-1:0] ram_rdaddr, ram_wraddr;
    logic [W-1:0]  ram_rddata, ram_wrdata;

    ram_arbiter #(.WIDTH(W), .SIZE(S), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_wrdata(ram_wrdata)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // RAM with registered read, preloaded on the first edge
    logic [W-1:0] ram [S];
    logic         ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < S; i++) ram[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_wren) ram[ram_wraddr] <= ram_wrdata;
            if (ram_rden) ram_rddata <= ram[ram_rdaddr];
        end
    end

    // Reference model: who last won, how long its run is, pending responses, memory contents
    int           m_last, m_run, eg;
    logic [1:0]   m_pend, m_seen;
    logic [W-1:0] m_pdata [2];
    logic [W-1:0] m_hold [2];
    logic [W-1:0] ref_mem [S];
    logic         m_loaded = 1'b0;

    always_comb begin
        eg = -1;
        if (req0_valid && req1_valid) eg = (m_run < MB) ? m_last : 1 - m_last;
        else if (req0_valid)          eg = 0;
        else if (req1_valid)          eg = 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last <= 0;
            m_run  <= 0;
            m_pend <= '0;
            m_seen <= '0;
            if (!m_loaded) begin
                for (int i = 0; i < S; i++) ref_mem[i] <= pat(i);
                m_loaded <= 1'b1;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (m_pend[n]) begin
                    m_hold[n] <= m_pdata[n];
                    m_seen[n] <= 1'b1;
                end
            end
            m_pend[0] <= (eg == 0) && !req0_we;
            m_pend[1] <= (eg == 1) && !req1_we;
            if (eg == 0) m_pdata[0] <= ref_mem[req0_addr];
            if (eg == 1) m_pdata[1] <= ref_mem[req1_addr];
            if (eg == 0 && req0_we) ref_mem[req0_addr] <= req0_wdata;
            if (eg == 1 && req1_we) ref_mem[req1_addr] <= req1_wdata;
            if (eg < 0) begin
                m_run <= 0;
            end else if (eg == m_last) begin
                m_run <= (m_run < MB) ? m_run + 1 : MB;
            end else begin
                m_last <= eg;
                m_run  <= 1;
            end
        end
    end

    int c_tot = 0, c_bad = 0, l_tot = 0, l_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        c_tot++;
        if (act !== exp) begin
            c_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lchk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        l_tot++;
        if (act !== exp) begin
            l_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rden", 64'(ram_rden), 64'(0));
            chk("rst_wren", 64'(ram_wren), 64'(0));
            chk("rst_rsp0v", 64'(rsp0_valid), 64'(0));
            chk("rst_rsp1v", 64'(rsp1_valid), 64'(0));
        end else begin
            chk("ready0", 64'(req0_ready), 64'(eg == 0));
            chk("ready1", 64'(req1_ready), 64'(eg == 1));
            chk("no_conflict", 64'(ram_rden & ram_wren), 64'(0));
            chk("wren", 64'(ram_wren), 64'(eg == 0 ? req0_we : eg == 1 ? req1_we : 1'b0));
            chk("rden", 64'(ram_rden), 64'(eg == 0 ? !req0_we : eg == 1 ? !req1_we : 1'b0));
            if (ram_wren) begin
                chk("wraddr", 64'(ram_wraddr), 64'(eg == 1 ? req1_addr : req0_addr));
                chk("wrdata", ram_wrdata, eg == 1 ? req1_wdata : req0_wdata);
            end
            if (ram_rden) chk("rdaddr", 64'(ram_rdaddr), 64'(eg == 1 ? req1_addr : req0_addr));
            chk("rsp0_valid", 64'(rsp0_valid), 64'(m_pend[0]));
            chk("rsp1_valid", 64'(rsp1_valid), 64'(m_pend[1]));
            if (m_pend[0])      chk("rsp0_data", rsp0_data, m_pdata[0]);
            else if (m_seen[0]) chk("rsp0_hold", rsp0_data, m_hold[0]);
            if (m_pend[1])      chk("rsp1_data", rsp1_data, m_pdata[1]);
            else if (m_seen[1]) chk("rsp1_hold", rsp1_data, m_hold[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int t3_g[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int t4_r0[5] = '{1, 1, 1, 1, 0};

    initial begin
        // reset with no requests
        repeat (2) @(posedge clk);
        #2;
        lchk("t1_rst_rden", 64'(ram_rden), 64'(0));
        lchk("t1_rst_wren", 64'(ram_wren), 64'(0));
        step();
        rst_n = 1'b1;

        // solo write then read of the same address
        step();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'd3; req0_wdata = 64'hA5;
        #1 lchk("t2_wr_ready", 64'(req0_ready), 64'(1));
        lchk("t2_wr_wren", 64'(ram_wren), 64'(1));
        step();
        req0_we = 1'b0;
        #1 lchk("t2_rd_ready", 64'(req0_ready), 64'(1));
        lchk("t2_rd_rden", 64'(ram_rden), 64'(1));
        step();
        req0_valid = 1'b0;
        #1 lchk("t2_rsp_valid", 64'(rsp0_valid), 64'(1));
        lchk("t2_rsp_data", rsp0_data, 64'hA5);
        step();
        #1 lchk("t2_rsp_once", 64'(rsp0_valid), 64'(0));

        // contention straight out of reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd10;
            req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd11;
            #1 lchk($sformatf("t3_ready0_%0d", i), 64'(req0_ready), 64'(t3_g[i] == 0));
            lchk($sformatf("t3_ready1_%0d", i), 64'(req1_ready), 64'(t3_g[i] == 1));
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // idle gap clears the burst count
        step(); req0_valid = 1'b1; req0_addr = 9'd12;
        step();
        step(); req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            req0_valid = 1'b1; req1_valid = 1'b1; req1_addr = 9'd13;
            #1 lchk($sformatf("t4_ready0_%0d", i), 64'(req0_ready), 64'(t4_r0[i]));
            lchk($sformatf("t4_ready1_%0d", i), 64'(req1_ready), 64'(t4_r0[i] == 0));
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // interleaved reads of preloaded words
        step();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd5;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd6;
        #1 lchk("t5_rsp0_valid", 64'(rsp0_valid), 64'(1));
        lchk("t5_rsp0_data", rsp0_data, 64'hC0DE_0000_0000_0005);
        step();
        req1_valid = 1'b0;
        #1 lchk("t5_rsp1_valid", 64'(rsp1_valid), 64'(1));
        lchk("t5_rsp0_gone", 64'(rsp0_valid), 64'(0));
        lchk("t5_rsp1_data", rsp1_data, 64'hC0DE_0000_0000_0006);

        // same-address write and read collide; owner (req1) wins, write retried
        step();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'd20; req0_wdata = 64'h1234;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'd20;
        #1 lchk("t6_ready1", 64'(req1_ready), 64'(1));
        lchk("t6_ready0_lose", 64'(req0_ready), 64'(0));
        step();
        req1_valid = 1'b0;
        #1 lchk("t6_ready0_retry", 64'(req0_ready), 64'(1));
        lchk("t6_rden_off", 64'(ram_rden), 64'(0));
        lchk("t6_old_data", rsp1_data, 64'hC0DE_0000_0000_0014);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        #1 lchk("t6_new_data", rsp1_data, 64'h1234);

        // reset while a read response is in flight
        step();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'd7;
        step();
        req0_valid = 1'b0;
        #1 lchk("t1_inflight", 64'(rsp0_valid), 64'(1));
        rst_n = 1'b0;
        #1 lchk("t1_drop_rsp0", 64'(rsp0_valid), 64'(0));
        lchk("t1_drop_rsp1", 64'(rsp1_valid), 64'(0));
        lchk("t1_rden_rst", 64'(ram_rden), 64'(0));
        lchk("t1_wren_rst", 64'(ram_wren), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", c_tot + l_tot, c_bad + l_bad);
        $finish;
    end

endmodule
